// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD operand feeder and the hgcd wrapper.
package gcd_pkg;

  localparam int unsigned GCD_WIDTH        = 8;
  localparam int unsigned GCD_MAX_INFLIGHT = 2;

  typedef struct packed {
    logic [GCD_WIDTH-1:0] a;
    logic [GCD_WIDTH-1:0] b;
  } gcd_pair_t;

  // Next in-flight count: add the pending ld and retire a rdy, clamped to 0..GCD_MAX_INFLIGHT.
  function automatic logic [1:0] inflight_next(logic [1:0] cnt, logic ld, logic rdy);
    logic [2:0] sum;
    sum = {1'b0, cnt} + {2'b00, ld};
    if (rdy && (sum != 3'd0)) begin
      sum = sum - 3'd1;
    end
    if (sum > 3'(GCD_MAX_INFLIGHT)) begin
      sum = 3'(GCD_MAX_INFLIGHT);
    end
    return sum[1:0];
  endfunction

endpackage

// File: rtl/gcd_feeder_if.sv
// Producer handshake plus the hgcd load/return signals seen by gcd_feeder.
interface gcd_feeder_if
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH = GCD_WIDTH
) ();

  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ld;
  logic             rdy;

  modport master (
    output in_a, in_b, in_valid, rdy,
    input  in_ready, a, b, ld
  );

  modport slave (
    input  in_a, in_b, in_valid, rdy,
    output in_ready, a, b, ld
  );

endinterface

// File: rtl/gcd_op_fifo.sv
// Synchronous operand FIFO; level is the pointer difference with one extra wrap bit.
module gcd_op_fifo #(
  parameter  int unsigned WIDTH = 16,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic             wr_en;
  logic             rd_en;

  assign level = wptr_q - rptr_q;
  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);
  assign rdata = mem_q[rptr_q[AW-1:0]];

  // A pop frees the head slot this cycle, so a simultaneous push is safe even when full.
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (wr_en) begin
      wptr_d = wptr_q + 1'b1;
    end
    if (rd_en) begin
      rptr_d = rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wptr_q[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/gcd_feeder.sv
// Buffers operand pairs and issues them to hgcd as ld pulses, tracking jobs in flight.
module gcd_feeder
  import gcd_pkg::*;
#(
  parameter  int unsigned WIDTH = GCD_WIDTH,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  gcd_feeder_if.slave   bus,
  output logic [1:0]    inflight,
  output logic [LW-1:0] level,
  output logic          err
);

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             ld_q, ld_d;
  logic [1:0]       inflight_q, inflight_d;
  logic             err_q, err_d;

  logic             push;
  logic             issue;
  logic             full;
  logic             empty;
  logic [2*WIDTH-1:0] head;

  assign bus.in_ready = !full;
  assign push         = bus.in_valid && !full;

  gcd_op_fifo #(
    .WIDTH (2 * WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata ({bus.in_a, bus.in_b}),
    .pop   (issue),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  always_comb begin
    inflight_d = inflight_next(inflight_q, ld_q, bus.rdy);
    // rdy at a full count means both engines finished; hgcd ignores ld in its replay cycle.
    issue = !empty
         && (inflight_d < 2'(GCD_MAX_INFLIGHT))
         && !(bus.rdy && (inflight_q == 2'(GCD_MAX_INFLIGHT)));
    a_d   = a_q;
    b_d   = b_q;
    ld_d  = 1'b0;
    if (issue) begin
      a_d  = head[2*WIDTH-1:WIDTH];
      b_d  = head[WIDTH-1:0];
      ld_d = 1'b1;
    end
    err_d = err_q || (bus.rdy && (inflight_q == 2'd0));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      a_q        <= '0;
      b_q        <= '0;
      ld_q       <= 1'b0;
      inflight_q <= 2'd0;
      err_q      <= 1'b0;
    end else begin
      a_q        <= a_d;
      b_q        <= b_d;
      ld_q       <= ld_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  assign bus.a    = a_q;
  assign bus.b    = b_q;
  assign bus.ld   = ld_q;
  assign inflight = inflight_q;
  assign err      = err_q;

endmodule

// File: tb/tb_gcd_feeder.sv
// Directed bench for gcd_feeder: single job, fill, drain hold, single completion, reset, err.
module tb_gcd_feeder;

  logic       clk;
  logic       reset;
  logic [1:0] inflight;
  logic [2:0] level;
  logic       err;

  int checks = 0;
  int errors = 0;

  logic [7:0] pa [8];
  logic [7:0] pb [8];
  int         exp_level    [6];
  int         exp_ld       [6];
  int         exp_inflight [6];

  gcd_feeder_if #(.WIDTH(8)) bus ();

  gcd_feeder #(
    .WIDTH (8),
    .DEPTH (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .inflight (inflight),
    .level    (level),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    pa = '{8'd12, 8'd35, 8'd81, 8'd100, 8'd64, 8'd21, 8'd90, 8'd77};
    pb = '{8'd8,  8'd14, 8'd27, 8'd75,  8'd40, 8'd6,  8'd36, 8'd11};
    exp_level    = '{1, 1, 1, 2, 3, 4};
    exp_ld       = '{0, 1, 1, 0, 0, 0};
    exp_inflight = '{0, 0, 1, 2, 2, 2};

    reset        = 1'b0;
    bus.in_a     = '0;
    bus.in_b     = '0;
    bus.in_valid = 1'b0;
    bus.rdy      = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    chk("rst_level", level, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_ld", bus.ld, 0);
    chk("rst_a", bus.a, 0);
    chk("rst_b", bus.b, 0);
    chk("rst_inflight", inflight, 0);
    chk("rst_err", err, 0);

    // Single job (48,18)
    bus.in_a = 8'd48;
    bus.in_b = 8'd18;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("t1_level_push", level, 1);
    chk("t1_ld_early", bus.ld, 0);
    tick();
    chk("t1_ld", bus.ld, 1);
    chk("t1_a", bus.a, 48);
    chk("t1_b", bus.b, 18);
    chk("t1_level_pop", level, 0);
    tick();
    chk("t1_ld_pulse", bus.ld, 0);
    chk("t1_inflight1", inflight, 1);
    chk("t1_a_hold", bus.a, 48);
    tick();
    tick();
    tick();
    bus.rdy = 1'b1;
    tick();
    bus.rdy = 1'b0;
    chk("t1_inflight0", inflight, 0);
    chk("t1_err", err, 0);
    chk("t1_empty", level, 0);

    // Fill: stream pairs until the FIFO is full
    bus.in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.in_a = pa[i];
      bus.in_b = pb[i];
      chk("t2_in_ready", bus.in_ready, 1);
      tick();
      chk("t2_level", level, exp_level[i]);
      chk("t2_ld", bus.ld, exp_ld[i]);
      chk("t2_inflight", inflight, exp_inflight[i]);
      if (i == 1) chk("t2_a_p1", bus.a, pa[0]);
      if (i == 2) begin
        chk("t2_a_p2", bus.a, pa[1]);
        chk("t2_b_p2", bus.b, pb[1]);
      end
    end
    bus.in_a = pa[6];
    bus.in_b = pb[6];
    chk("t2_full_ready", bus.in_ready, 0);
    tick();
    chk("t2_held_level", level, 4);
    chk("t2_held_ready", bus.in_ready, 0);
    chk("t2_a_hold", bus.a, pa[1]);
    bus.in_valid = 1'b0;

    // Drain hold: two consecutive rdy from a full count
    bus.rdy = 1'b1;
    tick();
    chk("t3_sw_ld", bus.ld, 0);
    chk("t3_sw_inflight", inflight, 1);
    chk("t3_sw_level", level, 4);
    tick();
    bus.rdy = 1'b0;
    chk("t3_ld_p3", bus.ld, 1);
    chk("t3_a_p3", bus.a, pa[2]);
    chk("t3_b_p3", bus.b, pb[2]);
    chk("t3_inflight0", inflight, 0);
    chk("t3_level3", level, 3);
    tick();
    chk("t3_ld_p4", bus.ld, 1);
    chk("t3_a_p4", bus.a, pa[3]);
    chk("t3_inflight1", inflight, 1);
    chk("t3_level2", level, 2);
    tick();
    chk("t3_ld_stop", bus.ld, 0);
    chk("t3_inflight2", inflight, 2);
    chk("t3_err", err, 0);

    // Single completion from a full count
    bus.rdy = 1'b1;
    tick();
    bus.rdy = 1'b0;
    chk("t4_ld_block", bus.ld, 0);
    chk("t4_inflight1", inflight, 1);
    tick();
    chk("t4_ld_p5", bus.ld, 1);
    chk("t4_a_p5", bus.a, pa[4]);
    chk("t4_b_p5", bus.b, pb[4]);
    chk("t4_level1", level, 1);
    tick();
    chk("t4_ld_stop", bus.ld, 0);
    chk("t4_inflight2", inflight, 2);

    // Reset mid-run with 3 queued and 2 in flight
    bus.in_valid = 1'b1;
    bus.in_a = pa[6];
    bus.in_b = pb[6];
    tick();
    bus.in_a = pa[7];
    bus.in_b = pb[7];
    tick();
    bus.in_valid = 1'b0;
    chk("t5_pre_level", level, 3);
    chk("t5_pre_inflight", inflight, 2);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("t5_level", level, 0);
    chk("t5_inflight", inflight, 0);
    chk("t5_ld", bus.ld, 0);
    chk("t5_a", bus.a, 0);
    chk("t5_b", bus.b, 0);
    chk("t5_err", err, 0);
    chk("t5_in_ready", bus.in_ready, 1);
    tick();
    chk("t5_ld_after", bus.ld, 0);

    // Spurious rdy at zero count
    bus.rdy = 1'b1;
    tick();
    bus.rdy = 1'b0;
    chk("t6_err", err, 1);
    chk("t6_inflight", inflight, 0);
    tick();
    tick();
    tick();
    chk("t6_err_sticky", err, 1);
    chk("t6_inflight_hold", inflight, 0);
    chk("t6_ld", bus.ld, 0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("t6_err_clr", err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
